// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Package : debug_pkg
// Brief   : shared encodings, frame geometry and checksum for the debug frame TX
// Rev     : 1.0 - initial release
// ============================================================================
package debug_pkg;

  localparam int         FRAME_BYTES       = 9;
  localparam int         NUM_PORTS         = 7;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] port_sum(input logic [NUM_PORTS*8-1:0] ports);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      acc = acc + ports[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_byte
// Brief  : 8N1 byte serialiser (LSB first) with baud counter and load/ready handshake
// Rev    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       ready,
  output logic       byte_end,
  output logic       tx
);

  localparam logic [15:0] c_BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state, w_state_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [2:0]  r_bit, w_bit_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic        r_tx, w_tx_nx;
  logic        w_bit_end;

  assign w_bit_end = (r_cnt == c_BIT_LAST);
  assign byte_end  = (r_state == ST_STOP) && w_bit_end;
  // Ready in the final stop-bit cycle so a queued byte follows with no idle gap.
  assign ready     = (r_state == ST_IDLE) || byte_end;
  assign tx        = r_tx;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 16'd1;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    if (load && ready) begin
      w_state_nx = ST_START;
      w_cnt_nx   = '0;
      w_bit_nx   = '0;
      w_shift_nx = byte_in;
      w_tx_nx    = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_cnt_nx = '0;
      w_tx_nx  = 1'b1;
    end else if (w_bit_end) begin
      w_cnt_nx = '0;
      case (r_state)
        ST_START: begin
          w_state_nx = ST_DATA;
          w_tx_nx    = r_shift[0];
        end
        ST_DATA: begin
          if (r_bit == 3'd7) begin
            w_state_nx = ST_STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx   = r_bit + 3'd1;
            w_shift_nx = {1'b0, r_shift[7:1]};
            w_tx_nx    = r_shift[1];
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_tx_nx    = 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_frame_tx.sv
`default_nettype none
// ============================================================================
// Module : debug_frame_tx
// Brief  : snapshots seven CPU debug ports and sends them as one framed UART packet
// Rev    : 1.0 - initial release
// ============================================================================
module debug_frame_tx
  import debug_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  input  logic       sample,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] drop_count
);

  state_t                 r_state, w_state_nx;
  logic [7:0]             r_snap [NUM_PORTS];
  logic [7:0]             r_chk;
  logic [3:0]             r_idx;
  logic [7:0]             r_drop;
  logic [NUM_PORTS*8-1:0] w_ports;
  logic                   w_accept;
  logic                   w_last_byte;
  logic                   w_load;
  logic                   w_ready;
  logic                   w_byte_end;
  logic [7:0]             w_byte;

  assign w_ports     = {debug_port7, debug_port6, debug_port5, debug_port4,
                        debug_port3, debug_port2, debug_port1};
  assign w_accept    = (r_state == ST_IDLE) && sample;
  assign w_last_byte = (r_idx == 4'(FRAME_BYTES - 1));
  assign w_load      = w_ready && (w_accept || (w_byte_end && !w_last_byte));

  // r_idx is the byte on the line, so the byte queued behind it is snap[r_idx] or the checksum.
  always_comb begin
    w_byte = r_chk;
    if (w_accept) begin
      w_byte = SYNC_BYTE;
    end else if (r_idx < 4'(NUM_PORTS)) begin
      w_byte = r_snap[r_idx[2:0]];
    end
  end

  // Bit-level START/DATA/STOP phases live in uart_tx_byte; ST_START here spans the whole frame.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (sample) w_state_nx = ST_START;
      ST_DONE: w_state_nx = ST_IDLE;
      default: if (w_byte_end && w_last_byte) w_state_nx = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_chk   <= '0;
      r_idx   <= '0;
      r_drop  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          r_snap[i] <= w_ports[i*8 +: 8];
        end
        r_chk <= port_sum(w_ports);
        r_idx <= '0;
      end else if (w_byte_end && !w_last_byte) begin
        r_idx <= r_idx + 4'd1;
      end
      if (sample && (r_state != ST_IDLE) && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk      (clk),
    .nreset   (nreset),
    .load     (w_load),
    .byte_in  (w_byte),
    .ready    (w_ready),
    .byte_end (w_byte_end),
    .tx       (uart_tx)
  );

  assign busy       = (r_state == ST_START);
  assign frame_done = (r_state == ST_DONE);
  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_debug_frame_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_debug_frame_tx
// Brief  : directed self-checking bench for debug_frame_tx with a mid-bit UART monitor
// Rev    : 1.0 - initial release
// ============================================================================
module tb_debug_frame_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 90 * CPB;

  logic       clk = 1'b0;
  logic       nreset;
  logic       sample;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7;
  logic       uart_tx, busy, frame_done;
  logic [7:0] drop_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] rx_q [$];
  int         rx_err      = 0;
  int         busy_cycles = 0;
  int         done_pulses = 0;
  bit         rx_abort;
  logic       rx_start;
  logic [7:0] rx_b;

  debug_frame_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .nreset(nreset),
    .debug_port1(p1), .debug_port2(p2), .debug_port3(p3), .debug_port4(p4),
    .debug_port5(p5), .debug_port6(p6), .debug_port7(p7),
    .sample(sample), .uart_tx(uart_tx), .busy(busy),
    .frame_done(frame_done), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (frame_done === 1'b1) done_pulses++;
  end

  // UART monitor: falling edge seen on a negedge, then samples at bit centres.
  task rx_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (nreset !== 1'b1) rx_abort = 1'b1;
    end
  endtask

  always begin
    @(negedge clk);
    if (nreset === 1'b1 && uart_tx === 1'b0) begin
      rx_abort = 1'b0;
      rx_wait(2);
      rx_start = uart_tx;
      for (int k = 0; k < 8; k++) begin
        rx_wait(CPB);
        rx_b[k] = uart_tx;
      end
      rx_wait(CPB);
      if (!rx_abort) begin
        rx_q.push_back(rx_b);
        if (rx_start !== 1'b0 || uart_tx !== 1'b1) rx_err++;
      end
    end
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task set_ports(input logic [7:0] a, b, c, d, e, f, g);
    p1 = a; p2 = b; p3 = c; p4 = d; p5 = e; p6 = f; p7 = g;
  endtask

  task automatic pulse_sample();
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    sample = 1'b0;
    set_ports(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL reset_drop_count: got %h expected 00", drop_count); end
    repeat (3) tick();
    nreset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int base, err0, busy0, done0, cyc;
    logic [7:0] exp [9];
    logic [7:0] got;
    exp  = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1C};
    base = rx_q.size(); err0 = rx_err; busy0 = busy_cycles; done0 = done_pulses;
    set_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    pulse_sample();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_accept: got %b expected 1", busy); end
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL basic_start_bit: got %b expected 0", uart_tx); end
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    n_checks++; if (cyc != FRAME_CYC) begin n_fail++; $display("FAIL basic_frame_length: got %0d expected %0d", cyc, FRAME_CYC); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL basic_tx_in_done: got %b expected 1", uart_tx); end
    tick();
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got %b expected 0", frame_done); end
    n_checks++; if (busy_cycles - busy0 != FRAME_CYC) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cycles - busy0, FRAME_CYC); end
    n_checks++; if (done_pulses - done0 != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_pulses - done0); end
    n_checks++; if (rx_q.size() - base != 9) begin n_fail++; $display("FAIL basic_byte_count: got %0d expected 9", rx_q.size() - base); end
    for (int i = 0; i < 9; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
    n_checks++; if (rx_err != err0) begin n_fail++; $display("FAIL basic_framing: got %0d errors expected 0", rx_err - err0); end
    n_checks++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL basic_drop_count: got %h expected 00", drop_count); end
  endtask

  task automatic test_checksum_wrap();
    int base, err0, cyc;
    logic [7:0] exp [9];
    logic [7:0] got;
    exp  = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9};
    base = rx_q.size(); err0 = rx_err;
    set_ports(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pulse_sample();
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL wrap_frame_done: got %b expected 1 (timeout)", frame_done); end
    tick();
    for (int i = 0; i < 9; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
    n_checks++; if (rx_err != err0) begin n_fail++; $display("FAIL wrap_framing: got %0d errors expected 0", rx_err - err0); end
  endtask

  task automatic test_snapshot();
    int base, cyc;
    logic [7:0] exp [9];
    logic [7:0] got;
    exp  = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hDC};
    base = rx_q.size();
    set_ports(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77);
    pulse_sample();
    set_ports(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL snap_frame_done: got %b expected 1 (timeout)", frame_done); end
    tick();
    for (int i = 0; i < 9; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL snap_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_drop_saturate();
    int base, cyc;
    logic [7:0] exp [9];
    logic [7:0] got;
    exp  = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'hC0};
    base = rx_q.size();
    set_ports(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70);
    sample = 1'b1;
    tick();
    set_ports(8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    repeat (100) tick();
    n_checks++; if (drop_count !== 8'd100) begin n_fail++; $display("FAIL drop_count_100: got %0d expected 100", drop_count); end
    repeat (200) tick();
    sample = 1'b0;
    n_checks++; if (drop_count !== 8'hFF) begin n_fail++; $display("FAIL drop_saturate: got %0d expected 255", drop_count); end
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    tick();
    n_checks++; if (drop_count !== 8'hFF) begin n_fail++; $display("FAIL drop_hold: got %0d expected 255", drop_count); end
    for (int i = 0; i < 9; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL drop_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, err0, cyc;
    logic [7:0] exp [9];
    logic [7:0] got;
    exp = '{8'hA5, 8'hC3, 8'h5A, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h81, 8'hE3};
    set_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    pulse_sample();
    repeat (99) tick();
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre_tx: got %b expected 0", uart_tx); end
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx_async: got %b expected 1", uart_tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy_async: got %b expected 0", busy); end
    n_checks++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL rst_mid_drop_clear: got %0d expected 0", drop_count); end
    repeat (3) tick();
    nreset = 1'b1;
    repeat (60) tick();
    base = rx_q.size(); err0 = rx_err;
    set_ports(8'hC3, 8'h5A, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h81);
    pulse_sample();
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    n_checks++; if (cyc != FRAME_CYC) begin n_fail++; $display("FAIL rst_mid_frame_length: got %0d expected %0d", cyc, FRAME_CYC); end
    tick();
    for (int i = 0; i < 9; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL rst_mid_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
    n_checks++; if (rx_err != err0) begin n_fail++; $display("FAIL rst_mid_framing: got %0d errors expected 0", rx_err - err0); end
  endtask

  task automatic test_back_to_back();
    int base, err0, done0, cyc;
    logic [7:0] exp [18];
    logic [7:0] got;
    exp = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h7F,
            8'hA5, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7A};
    base = rx_q.size(); err0 = rx_err; done0 = done_pulses;
    set_ports(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);
    pulse_sample();
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    tick();
    set_ports(8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF);
    pulse_sample();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL b2b_second_start: got %b expected 0", uart_tx); end
    n_checks++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL b2b_no_drop: got %0d expected 0", drop_count); end
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    n_checks++; if (cyc != FRAME_CYC) begin n_fail++; $display("FAIL b2b_frame_length: got %0d expected %0d", cyc, FRAME_CYC); end
    tick();
    n_checks++; if (done_pulses - done0 != 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_pulses - done0); end
    for (int i = 0; i < 18; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got, exp[i]); end
    end
    n_checks++; if (rx_err != err0) begin n_fail++; $display("FAIL b2b_framing: got %0d errors expected 0", rx_err - err0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum_wrap();
    test_snapshot();
    test_drop_saturate();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
